// File: rtl/mem_pkg.sv
// Shared definitions for the line transfer unit.
//   MEM_TAG_LO   : low 12 bits of every tag sent toward the memory arbiter
//   TAG_READ_BIT : tag bit that marks a read (1) or a write (0)
//   LINE_BYTES   : cache line size in bytes (also sets the address alignment)
//   ltu_state_t  : controller state encoding, exposed on the debug port
package mem_pkg;

    localparam logic [11:0] MEM_TAG_LO   = 12'h100;
    localparam int          TAG_READ_BIT = 12;
    localparam int          LINE_BYTES   = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_WAIT = 3'd5,
        DONE    = 3'd6
    } ltu_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Beat storage for one cache line: BEATS registers of WIDTH bits.
//   clk, reset_n : clock, asynchronous active-low reset (clears every beat)
//   load_en      : replace the whole line with load_data (has priority)
//   load_data    : flat line, beat k = bits [WIDTH*k +: WIDTH]
//   wr_en        : write one beat at wr_idx with wr_data
//   line_flat    : registered flat view of the stored line
module line_beat_buffer #(
    parameter int WIDTH = 64,
    parameter int BEATS = 8,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_en,
    input  logic [WIDTH*BEATS-1:0] load_data,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH*BEATS-1:0] line_flat
);

    logic [WIDTH-1:0] beat_q [BEATS];
    logic [WIDTH-1:0] beat_d [BEATS];

    always_comb begin
        beat_d = beat_q;
        if (load_en) begin
            for (int k = 0; k < BEATS; k++) begin
                beat_d[k] = load_data[k*WIDTH +: WIDTH];
            end
        end else if (wr_en) begin
            beat_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < BEATS; k++) begin
                beat_q[k] <= '0;
            end
        end else begin
            beat_q <= beat_d;
        end
    end

    always_comb begin
        line_flat = '0;
        for (int k = 0; k < BEATS; k++) begin
            line_flat[k*WIDTH +: WIDTH] = beat_q[k];
        end
    end

endmodule

// File: rtl/line_transfer_unit.sv
// Moves one cache line between the cache and the memory arbiter.
// A fill sends the line address, then collects BEATS read beats; a writeback
// sends the address, then BEATS write beats, then waits for the commit ack.
//
// Ports
//   clk, reset_n   : clock, asynchronous active-low reset
//   cache_valid/cache_ready : request handshake (accept when both are 1)
//   cache_write    : 1 = writeback of cache_wdata, 0 = fill
//   cache_addr     : byte address; offset bits inside the line are dropped
//   cache_wdata    : writeback line, beat k = bits [64k+63:64k]
//   cache_done     : one-cycle completion pulse
//   cache_rdata    : filled line, held until the next accept
//   arb_reqcyc/arb_req/arb_reqtag/arb_reqack : request channel to the arbiter
//   arb_respcyc/arb_resp/arb_respack         : read-data channel
//   arb_writeack   : write burst committed
//   dbg_state      : current controller state
//
// Handshakes: a beat on arb_req transfers on every cycle with arb_reqcyc=1
// and arb_reqack=1. A read beat transfers on every cycle with arb_respcyc=1
// and arb_respack=1; arb_respack is a registered "ready" that is high for the
// whole RD_DATA state, so the ack coincides with the beat it acknowledges
// without any combinational path from arb_* inputs to arb_* outputs.
module line_transfer_unit
    import mem_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int BEATS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cache_valid,
    output logic                   cache_ready,
    input  logic                   cache_write,
    input  logic [WIDTH-1:0]       cache_addr,
    input  logic [WIDTH*BEATS-1:0] cache_wdata,
    output logic                   cache_done,
    output logic [WIDTH*BEATS-1:0] cache_rdata,
    output logic                   arb_reqcyc,
    output logic [WIDTH-1:0]       arb_req,
    output logic [12:0]            arb_reqtag,
    input  logic                   arb_reqack,
    input  logic                   arb_respcyc,
    input  logic [WIDTH-1:0]       arb_resp,
    output logic                   arb_respack,
    input  logic                   arb_writeack,
    output ltu_state_t             dbg_state
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [WIDTH-1:0] OFS_MASK  = WIDTH'(LINE_BYTES - 1);

    ltu_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       addr_q, addr_d;
    logic                   write_q, write_d;
    logic                   cache_ready_q, cache_ready_d;
    logic                   cache_done_q, cache_done_d;
    logic                   arb_reqcyc_q, arb_reqcyc_d;
    logic [WIDTH-1:0]       arb_req_q, arb_req_d;
    logic [12:0]            arb_reqtag_q, arb_reqtag_d;
    logic                   arb_respack_q, arb_respack_d;

    logic                   buf_load_en;
    logic [WIDTH*BEATS-1:0] buf_load_data;
    logic                   buf_wr_en;
    logic [WIDTH*BEATS-1:0] line_flat;

    // A fill loads an all-zero line so nothing from an earlier operation can
    // leak into the new result; a writeback loads the line to be sent.
    assign buf_load_data = cache_write ? cache_wdata : '0;

    line_beat_buffer #(
        .WIDTH (WIDTH),
        .BEATS (BEATS)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_en   (buf_load_en),
        .load_data (buf_load_data),
        .wr_en     (buf_wr_en),
        .wr_idx    (cnt_q),
        .wr_data   (arb_resp),
        .line_flat (line_flat)
    );

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        buf_load_en = 1'b0;
        buf_wr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cache_valid && cache_ready_q) begin
                    addr_d      = cache_addr & ~OFS_MASK;
                    write_d     = cache_write;
                    cnt_d       = '0;
                    buf_load_en = 1'b1;
                    state_d     = cache_write ? WR_ADDR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arb_reqack) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (arb_respcyc) begin
                    buf_wr_en = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WR_ADDR: begin
                if (arb_reqack) state_d = WR_DATA;
            end
            WR_DATA: begin
                if (arb_reqack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (arb_writeack) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, all derived from the next state so
    // every output leaves a flop.
    always_comb begin
        cache_ready_d = (state_d == IDLE);
        cache_done_d  = (state_d == DONE);
        arb_respack_d = (state_d == RD_DATA);
        arb_reqcyc_d  = (state_d == RD_ADDR) || (state_d == WR_ADDR) ||
                        (state_d == WR_DATA);
        arb_req_d     = '0;
        arb_reqtag_d  = '0;
        if ((state_d == RD_ADDR) || (state_d == WR_ADDR)) begin
            arb_req_d = addr_d;
        end else if (state_d == WR_DATA) begin
            arb_req_d = line_flat[int'(cnt_d)*WIDTH +: WIDTH];
        end
        if (arb_reqcyc_d) begin
            arb_reqtag_d[TAG_READ_BIT] = ~write_d;
            arb_reqtag_d[11:0]         = MEM_TAG_LO;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            cache_ready_q <= 1'b1;
            cache_done_q  <= 1'b0;
            arb_reqcyc_q  <= 1'b0;
            arb_req_q     <= '0;
            arb_reqtag_q  <= '0;
            arb_respack_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            cache_ready_q <= cache_ready_d;
            cache_done_q  <= cache_done_d;
            arb_reqcyc_q  <= arb_reqcyc_d;
            arb_req_q     <= arb_req_d;
            arb_reqtag_q  <= arb_reqtag_d;
            arb_respack_q <= arb_respack_d;
        end
    end

    assign cache_ready = cache_ready_q;
    assign cache_done  = cache_done_q;
    assign cache_rdata = line_flat;
    assign arb_reqcyc  = arb_reqcyc_q;
    assign arb_req     = arb_req_q;
    assign arb_reqtag  = arb_reqtag_q;
    assign arb_respack = arb_respack_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_line_transfer_unit.sv
// Directed bench for line_transfer_unit: fills, a writeback, mid-burst reset
// and stray-input cases. Inputs change and outputs are sampled on the falling
// clock edge; beats are pushed to exp_q as driven and popped as they emerge.
module tb_line_transfer_unit;
    import mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cache_valid = 1'b0;
    logic         cache_ready;
    logic         cache_write = 1'b0;
    logic [63:0]  cache_addr = '0;
    logic [511:0] cache_wdata = '0;
    logic         cache_done;
    logic [511:0] cache_rdata;
    logic         arb_reqcyc;
    logic [63:0]  arb_req;
    logic [12:0]  arb_reqtag;
    logic         arb_reqack = 1'b0;
    logic         arb_respcyc = 1'b0;
    logic [63:0]  arb_resp = '0;
    logic         arb_respack;
    logic         arb_writeack = 1'b0;
    ltu_state_t   dbg_state;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  fill_beats [8];
    logic [511:0] last_line;

    line_transfer_unit #(.WIDTH(64), .BEATS(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cache_valid  (cache_valid),
        .cache_ready  (cache_ready),
        .cache_write  (cache_write),
        .cache_addr   (cache_addr),
        .cache_wdata  (cache_wdata),
        .cache_done   (cache_done),
        .cache_rdata  (cache_rdata),
        .arb_reqcyc   (arb_reqcyc),
        .arb_req      (arb_req),
        .arb_reqtag   (arb_reqtag),
        .arb_reqack   (arb_reqack),
        .arb_respcyc  (arb_respcyc),
        .arb_resp     (arb_resp),
        .arb_respack  (arb_respack),
        .arb_writeack (arb_writeack),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Fill with reqack one cycle after reqcyc rises; optional respcyc gap
    // after beat index gap_after; optional cache_valid held into DONE.
    task automatic do_fill(input logic [63:0] addr, input int gap_after,
                           input int gap_len, input bit hold_valid);
        logic [511:0] exp_line;
        check("fill_ready", cache_ready, 1'b1);
        cache_valid = 1'b1;
        cache_write = 1'b0;
        cache_addr  = addr;
        cache_wdata = {8{rnd64()}};
        tick();
        cache_valid = 1'b0;
        check("fill_state_addr", dbg_state, RD_ADDR);
        check("fill_reqcyc", arb_reqcyc, 1'b1);
        check("fill_req_addr", arb_req, {addr[63:6], 6'b0});
        check("fill_tag", arb_reqtag, 13'h1100);
        check("fill_busy", cache_ready, 1'b0);
        tick();
        check("fill_reqcyc_hold", arb_reqcyc, 1'b1);
        arb_reqack = 1'b1;
        tick();
        arb_reqack = 1'b0;
        check("fill_reqcyc_drop", arb_reqcyc, 1'b0);
        check("fill_state_data", dbg_state, RD_DATA);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(fill_beats[k]);
            arb_respcyc = 1'b1;
            arb_resp    = fill_beats[k];
            check("fill_respack", arb_respack, 1'b1);
            check("fill_no_early_done", cache_done, 1'b0);
            if (k == 7 && hold_valid) cache_valid = 1'b1;
            tick();
            arb_respcyc = 1'b0;
            arb_resp    = rnd64();
            if (k == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    check("fill_stall_state", dbg_state, RD_DATA);
                    check("fill_stall_done", cache_done, 1'b0);
                    tick();
                end
            end
        end
        check("fill_done", cache_done, 1'b1);
        check("fill_done_not_ready", cache_ready, 1'b0);
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            exp_line[k*64 +: 64] = exp_q.pop_front();
        end
        check("fill_rdata", cache_rdata, exp_line);
        last_line = exp_line;
        tick();
        check("fill_done_pulse", cache_done, 1'b0);
        check("fill_back_idle", dbg_state, IDLE);
        check("fill_ready_again", cache_ready, 1'b1);
        check("fill_rdata_held", cache_rdata, exp_line);
        if (hold_valid) begin
            cache_valid = 1'b0;
            tick();
            check("hold_no_second_accept", dbg_state, IDLE);
        end
    endtask

    // Writeback with every reqack delayed ack_delay cycles and writeack
    // arriving wack_delay cycles after the last beat's ack.
    task automatic do_wb(input logic [63:0] addr, input logic [511:0] line,
                         input int ack_delay, input int wack_delay);
        check("wb_ready", cache_ready, 1'b1);
        for (int k = 0; k < 8; k++) exp_q.push_back(line[k*64 +: 64]);
        cache_valid = 1'b1;
        cache_write = 1'b1;
        cache_addr  = addr;
        cache_wdata = line;
        tick();
        cache_valid = 1'b0;
        cache_write = 1'b0;
        check("wb_state_addr", dbg_state, WR_ADDR);
        check("wb_req_addr", arb_req, {addr[63:6], 6'b0});
        check("wb_tag", arb_reqtag, 13'h0100);
        for (int d = 0; d < ack_delay; d++) begin
            arb_writeack = 1'b1;  // stray: must not matter outside WR_WAIT
            tick();
            arb_writeack = 1'b0;
            check("wb_addr_hold", arb_req, {addr[63:6], 6'b0});
            check("wb_stray_wack", dbg_state, WR_ADDR);
        end
        arb_reqack = 1'b1;
        tick();
        arb_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("wb_state_data", dbg_state, WR_DATA);
            check("wb_reqcyc", arb_reqcyc, 1'b1);
            check("wb_data_tag", arb_reqtag, 13'h0100);
            for (int d = 0; d < ack_delay; d++) begin
                check("wb_beat_wait", arb_req, exp_q[0]);
                tick();
            end
            check("wb_beat", arb_req, exp_q.pop_front());
            arb_reqack = 1'b1;
            tick();
            arb_reqack = 1'b0;
        end
        check("wb_state_wait", dbg_state, WR_WAIT);
        check("wb_reqcyc_drop", arb_reqcyc, 1'b0);
        check("wb_queue_empty", exp_q.size(), 0);
        for (int d = 0; d < wack_delay; d++) begin
            check("wb_wait_no_done", cache_done, 1'b0);
            tick();
        end
        arb_writeack = 1'b1;
        tick();
        arb_writeack = 1'b0;
        check("wb_done", cache_done, 1'b1);
        for (int d = 0; d < 3; d++) begin
            tick();
            check("wb_single_done", cache_done, 1'b0);
        end
        check("wb_idle", dbg_state, IDLE);
    endtask

    initial begin
        logic [511:0] wb_line;

        // Reset state
        tick();
        tick();
        check("rst_reqcyc", arb_reqcyc, 1'b0);
        check("rst_respack", arb_respack, 1'b0);
        check("rst_done", cache_done, 1'b0);
        check("rst_req", arb_req, '0);
        check("rst_tag", arb_reqtag, '0);
        check("rst_rdata", cache_rdata, '0);
        reset_n = 1'b1;
        tick();
        check("rst_ready", cache_ready, 1'b1);
        check("rst_state", dbg_state, IDLE);

        // Basic fill: 0x11..0x88, done 11 cycles after accept
        for (int k = 0; k < 8; k++) fill_beats[k] = 64'(k + 1) * 64'h11;
        do_fill(64'h1000_0047, -1, 0, 1'b0);
        check("fill_beat0", cache_rdata[63:0], 64'h11);
        check("fill_beat7", cache_rdata[511:448], 64'h88);

        // Same fill with a 3-cycle respcyc gap after beat 4
        do_fill(64'h1000_0047, 3, 3, 1'b0);

        // Writeback 0xA0..0xA7, reqack delayed 2, writeack after 5
        for (int k = 0; k < 8; k++) wb_line[k*64 +: 64] = 64'hA0 + 64'(k);
        do_wb(64'h2000_013F, wb_line, 2, 5);

        // Stray respcyc / writeack while idle
        arb_respcyc  = 1'b1;
        arb_resp     = 64'hDEAD_BEEF_0BAD_F00D;
        arb_writeack = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tick();
            check("idle_no_respack", arb_respack, 1'b0);
            check("idle_state", dbg_state, IDLE);
            check("idle_no_done", cache_done, 1'b0);
        end
        arb_respcyc  = 1'b0;
        arb_writeack = 1'b0;

        // cache_valid held high into DONE
        for (int k = 0; k < 8; k++) fill_beats[k] = rnd64();
        do_fill(64'h0000_3F80, -1, 0, 1'b1);

        // Reset during RD_DATA beat 3
        cache_valid = 1'b1;
        cache_write = 1'b0;
        cache_addr  = 64'h4000_0000;
        tick();
        cache_valid = 1'b0;
        tick();
        arb_reqack = 1'b1;
        tick();
        arb_reqack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            arb_respcyc = 1'b1;
            arb_resp    = 64'hBAD0 + 64'(k);
            tick();
        end
        arb_resp = 64'hBAD3;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_reqcyc", arb_reqcyc, 1'b0);
        check("mid_rst_respack", arb_respack, 1'b0);
        check("mid_rst_done", cache_done, 1'b0);
        check("mid_rst_req", arb_req, '0);
        check("mid_rst_tag", arb_reqtag, '0);
        check("mid_rst_rdata", cache_rdata, '0);
        arb_respcyc = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_ready", cache_ready, 1'b1);

        // Fresh fill after reset
        for (int k = 0; k < 8; k++) fill_beats[k] = rnd64();
        do_fill(64'h4000_0008, 5, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/line_transfer_unit.md
LINE_TRANSFER_UNIT -- requirements
Module: line_transfer_unit

Interface
REQ-001 The unit SHALL have parameters WIDTH = 64 (beat width in bits) and BEATS = 8 (beats per cache line).
REQ-002 The unit SHALL use one clock, with reset asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cache_valid  in  1  the cache requests a line operation.
REQ-006 cache_ready  out  1  the unit is idle and accepts a request.
REQ-007 cache_write  in  1  1 = writeback of cache_wdata, 0 = line fill.
REQ-008 cache_addr  in  64  byte address of the line.
REQ-009 cache_wdata  in  512  writeback line; beat k = bits [64k+63:64k].
REQ-010 cache_done  out  1  one-cycle pulse: the operation is complete.
REQ-011 cache_rdata  out  512  filled line; valid while cache_done=1 and held until the next accept.
REQ-012 arb_reqcyc  out  1  request toward the arbiter is valid.
REQ-013 arb_req  out  64  address beat or write-data beat.
REQ-014 arb_reqtag  out  13  bit12 = 1 for read, 0 for write; bits[11:0] = MEM_TAG_LO.
REQ-015 arb_reqack  in  1  the arbiter accepted the current arb_req beat.
REQ-016 arb_respcyc  in  1  a read-data beat is valid on arb_resp.
REQ-017 arb_resp  in  64  read-data beat.
REQ-018 arb_respack  out  1  acknowledges the read beat presented this cycle.
REQ-019 arb_writeack  in  1  the write burst has been committed.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_WAIT, DONE.
REQ-021 A request SHALL be accepted when cache_valid=1 and cache_ready=1; cache_ready SHALL be 1 only in IDLE.
REQ-022 On accept, the unit SHALL latch the address with bits[5:0] forced to 0, latch cache_write and cache_wdata, and clear the 3-bit beat counter.
REQ-023 On accept, the next state SHALL be WR_ADDR if cache_write=1, otherwise RD_ADDR.
REQ-024 In RD_ADDR and WR_ADDR: arb_reqcyc=1, arb_req = latched address, and arb_reqtag = {cache_write ? 0 : 1, MEM_TAG_LO}.
REQ-025 When arb_reqack=1 in RD_ADDR, the unit SHALL deassert arb_reqcyc in the next cycle and move to RD_DATA.
REQ-026 In RD_DATA, each cycle with arb_respcyc=1 SHALL store arb_resp into beat[counter], increment the counter, and drive arb_respack=1 in the same cycle.
REQ-027 After beat 7 is stored (counter wraps 7->0), the unit SHALL move to DONE.
REQ-028 In RD_DATA, cycles with arb_respcyc=0 SHALL stall the unit without loss of data or state.
REQ-029 When arb_reqack=1 in WR_ADDR, the unit SHALL move to WR_DATA with arb_req = beat 0 and arb_reqcyc still 1.
REQ-030 In WR_DATA, each arb_reqack=1 SHALL advance to the next beat; the ack of beat 7 SHALL move the unit to WR_WAIT with arb_reqcyc=0.
REQ-031 In WR_WAIT, arb_writeack=1 SHALL move the unit to DONE; arb_writeack=1 in any other state SHALL be ignored.
REQ-032 DONE SHALL last exactly one cycle with cache_done=1, then the unit SHALL return to IDLE; cache_valid SHALL not be accepted during DONE.
REQ-033 arb_respcyc=1 outside RD_DATA SHALL be ignored: no capture and arb_respack=0.
REQ-034 Minimum latencies: fill = accept + 1 (addr) + 8 (beats) + 1 (DONE); writeback = accept + 1 + 8 + writeack wait + 1.
REQ-035 All outputs SHALL be registered; no combinational path from any arb_* input to any arb_* output.

Reset
REQ-036 Asserting reset_n=0 at any time, including mid-burst, SHALL immediately force IDLE, counter=0, arb_reqcyc=0, arb_respack=0, cache_done=0, and arb_req, arb_reqtag, cache_rdata = 0.
REQ-037 Asserting reset_n=0 SHALL discard any partially captured line.
REQ-038 After reset is released, cache_ready SHALL be 1 on the first clk edge.

Structure
REQ-039 Package mem_pkg SHALL hold MEM_TAG_LO (12'h100), TAG_READ_BIT (12), LINE_BYTES (64), and the state enum ltu_state_t.
REQ-040 Beat storage and indexing SHALL be one sub-module, line_beat_buffer (8x64 registers, write-by-index, 512-bit flat read).

Verification
REQ-041 Fill of 0x1000_0047 with arb_reqack one cycle after reqcyc and 8 consecutive beats 0x11..0x88 -> arb_req=0x1000_0040, tag bit12=1, cache_rdata[63:0]=0x11, cache_rdata[511:448]=0x88, cache_done 11 cycles after accept.
REQ-042 Same fill with arb_respcyc low for 3 cycles after beat 4 -> identical cache_rdata, cache_done delayed by exactly 3 cycles.
REQ-043 Writeback of line 0xA0..0xA7 with each reqack delayed 2 cycles and writeack 5 cycles after the last beat -> beats appear on arb_req in order 0xA0..0xA7, tag bit12=0, single cache_done pulse.
REQ-044 reset_n pulsed low during RD_DATA beat 3 -> all outputs 0 immediately; next fill returns fresh data with no stale beats.
REQ-045 Stray arb_respcyc and arb_writeack while in IDLE, and cache_valid held high during DONE -> no capture, no respack, no second accept until IDLE.
